// File: rtl/ff_array_pkg.sv
// Shared types and sizes for the FF-array initiator and its bench.
// Holds the command opcodes, FSM states and the wrapping beat-address helper.
package ff_array_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        OP_WRITE      = 2'b00,
        OP_READ       = 2'b01,
        OP_BURST_READ = 2'b10,
        OP_FILL       = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAP,
        ST_RESP,
        ST_ACK
    } state_e;

    // Addresses wrap naturally at DEPTH because ADDR_W bits hold exactly DEPTH entries.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return base + idx;
    endfunction

    function automatic logic is_write_op(input op_e op);
        return (op == OP_WRITE) || (op == OP_FILL);
    endfunction

    function automatic logic is_burst_op(input op_e op);
        return (op == OP_BURST_READ) || (op == OP_FILL);
    endfunction

endpackage

// File: rtl/ff_array_initiator_if.sv
// Command, response and FF-array target signals of the initiator in one bundle.
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
// valid, once raised, holds its payload stable until that edge.
interface ff_array_initiator_if;
    import ff_array_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic [DATA_W-1:0] cmd_data;

    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_error;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    // The initiator: takes commands, drives the target port, returns responses.
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
        input  mem_dout, mem_error, rsp_ready,
        output cmd_ready, mem_wr, mem_rd, mem_addr, mem_din,
        output rsp_valid, rsp_data, rsp_last, rsp_err
    );

    // The environment: issues commands, plays the FF-array target, consumes responses.
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data,
        output mem_dout, mem_error, rsp_ready,
        input  cmd_ready, mem_wr, mem_rd, mem_addr, mem_din,
        input  rsp_valid, rsp_data, rsp_last, rsp_err
    );

endinterface

// File: rtl/ff_array_initiator.sv
// Single/burst command initiator for a small FF-array target.
// One beat in flight at a time; every bus and response output comes straight from a flop.
module ff_array_initiator
    import ff_array_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    ff_array_initiator_if.slave   bus,
    output logic                  busy,
    output state_e                state_dbg
);

    state_e            state;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] beat_q;
    logic [DATA_W-1:0] data_q;

    logic              mem_wr_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_last_q;
    logic              err_q;

    logic              last_beat;
    logic [ADDR_W-1:0] next_addr;

    assign bus.cmd_ready = resetn && (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign state_dbg     = state;

    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.rsp_err   = err_q;

    // Single ops are one beat regardless of the length field they arrived with.
    assign last_beat = (beat_q == (is_burst_op(op_q) ? len_q : '0));
    assign next_addr = beat_addr(addr_q, beat_q + 1'b1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            op_q        <= OP_WRITE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            data_q      <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // The sticky error flag doubles as rsp_err; target errors seen while idle are ignored.
            if (state != ST_IDLE && bus.mem_error) begin
                err_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q       <= op_e'(bus.cmd_op);
                        addr_q     <= bus.cmd_addr;
                        len_q      <= bus.cmd_len;
                        data_q     <= bus.cmd_data;
                        beat_q     <= '0;
                        err_q      <= 1'b0;
                        mem_addr_q <= bus.cmd_addr;
                        if (is_write_op(op_e'(bus.cmd_op))) begin
                            mem_wr_q  <= 1'b1;
                            mem_din_q <= bus.cmd_data;
                            state     <= ST_WRITE;
                        end else begin
                            mem_rd_q  <= 1'b1;
                            state     <= ST_READ;
                        end
                    end
                end

                ST_WRITE: begin
                    if (last_beat) begin
                        mem_wr_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_din_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_last_q  <= 1'b1;
                        state       <= ST_ACK;
                    end else begin
                        beat_q      <= beat_q + 1'b1;
                        mem_addr_q  <= next_addr;
                        mem_din_q   <= data_q;
                    end
                end

                ST_READ: begin
                    mem_rd_q   <= 1'b0;
                    mem_addr_q <= '0;
                    state      <= ST_CAP;
                end

                ST_CAP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus.mem_dout;
                    rsp_last_q  <= last_beat;
                    state       <= ST_RESP;
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_last_q  <= 1'b0;
                        if (last_beat) begin
                            state <= ST_IDLE;
                        end else begin
                            beat_q     <= beat_q + 1'b1;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= next_addr;
                            state      <= ST_READ;
                        end
                    end
                end

                ST_ACK: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_last_q  <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_array_initiator.sv
// Bench for ff_array_initiator: FF-array target responder, command-level reference model,
// per-cycle compare process, directed scenarios and a randomized command run.
module tb_ff_array_initiator;
    import ff_array_pkg::*;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   resetn = 1'b0;
    logic   busy;
    state_e state_dbg;
    int     cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ff_array_initiator_if bus ();

    ff_array_initiator dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.slave),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- FF-array target ----------------
    logic [7:0] tgt_mem  [DEPTH];
    logic [7:0] init_val [DEPTH];
    logic       load_mem = 1'b0;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < DEPTH; i++) tgt_mem[i] <= init_val[i];
        end else if (bus.mem_wr) begin
            tgt_mem[bus.mem_addr] <= bus.mem_din;
        end
        if (bus.mem_rd) bus.mem_dout <= tgt_mem[bus.mem_addr];
    end

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  model_mem [DEPTH];
    logic [10:0] wr_exp_q[$];   // {addr, data} per write beat
    logic [2:0]  rd_exp_q[$];   // addr per read beat
    logic [8:0]  rsp_exp_q[$];  // {data, last} per response beat
    bit          m_busy = 0;
    bit          m_flag = 0;
    bit          m_is_wr = 0;
    int          acc_cyc, wr_idx, rd_beat, last_rd_cyc, last_wr_cyc, last_hs_cyc;

    logic [10:0] wr_log[$];
    int          wr_cyc_log[$];
    int          rd_cyc_log[$];
    int          rise_cyc_log[$];
    logic [9:0]  rsp_log[$];    // {data, last, err}

    bit          p_resetn = 0;
    bit          p_valid = 0;
    bit          p_ready = 0;
    logic [7:0]  p_data = '0;
    bit          p_last = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept();
        int         nb;
        logic [2:0] a;
        nb = bus.cmd_op[1] ? int'(bus.cmd_len) + 1 : 1;
        m_is_wr = (bus.cmd_op == 2'b00) || (bus.cmd_op == 2'b11);
        for (int i = 0; i < nb; i++) begin
            a = 3'((int'(bus.cmd_addr) + i) % DEPTH);
            if (m_is_wr) begin
                wr_exp_q.push_back({a, bus.cmd_data});
                model_mem[a] = bus.cmd_data;
            end else begin
                rd_exp_q.push_back(a);
                rsp_exp_q.push_back({model_mem[a], (i == nb - 1) ? 1'b1 : 1'b0});
            end
        end
        if (m_is_wr) rsp_exp_q.push_back({8'h00, 1'b1});
        m_busy = 1;
        m_flag = 0;
        acc_cyc = cyc;
        wr_idx = 0;
        rd_beat = 0;
        last_hs_cyc = cyc;
    endtask

    logic [10:0] e_wr;
    logic [2:0]  e_rd;
    logic [8:0]  e_rsp;
    bit          end_cmd;

    always @(negedge clk) begin
        end_cmd = 0;
        check("wr_rd_exclusive", {31'd0, bus.mem_wr & bus.mem_rd}, 32'd0);
        check("no_rd_while_rsp", {31'd0, bus.mem_rd & bus.rsp_valid}, 32'd0);
        if (!bus.mem_wr && !bus.mem_rd)
            check("idle_bus_zero", {21'd0, bus.mem_addr, bus.mem_din}, 32'd0);
        if (p_resetn && p_valid && !p_ready)
            check("rsp_hold", {bus.rsp_valid, bus.rsp_data, bus.rsp_last}, {1'b1, p_data, p_last});

        if (!resetn) begin
            wr_exp_q.delete();
            rd_exp_q.delete();
            rsp_exp_q.delete();
            m_busy = 0;
        end else begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !m_busy});
            if (bus.mem_wr) begin
                if (wr_exp_q.size() == 0) check("unexpected_mem_wr", 1, 0);
                else begin
                    e_wr = wr_exp_q.pop_front();
                    check("mem_wr_beat", {21'd0, bus.mem_addr, bus.mem_din}, {21'd0, e_wr});
                    check("mem_wr_cycle", cyc, acc_cyc + 1 + wr_idx);
                    wr_idx++;
                    last_wr_cyc = cyc;
                    wr_log.push_back({bus.mem_addr, bus.mem_din});
                    wr_cyc_log.push_back(cyc);
                end
            end
            if (bus.mem_rd) begin
                if (rd_exp_q.size() == 0) check("unexpected_mem_rd", 1, 0);
                else begin
                    e_rd = rd_exp_q.pop_front();
                    check("mem_rd_addr", {29'd0, bus.mem_addr}, {29'd0, e_rd});
                    if (rd_beat == 0) check("mem_rd_first_cycle", cyc, acc_cyc + 1);
                    else check("mem_rd_after_hs", {31'd0, cyc > last_hs_cyc}, 32'd1);
                    rd_beat++;
                    last_rd_cyc = cyc;
                    rd_cyc_log.push_back(cyc);
                end
            end
            if (bus.rsp_valid && !p_valid) begin
                if (!m_busy) check("unexpected_rsp", 1, 0);
                else if (m_is_wr) check("ack_rise_cycle", cyc, last_wr_cyc + 1);
                else check("rsp_rise_cycle", cyc, last_rd_cyc + 2);
                rise_cyc_log.push_back(cyc);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_exp_q.size() == 0) check("unexpected_rsp_beat", 1, 0);
                else begin
                    e_rsp = rsp_exp_q.pop_front();
                    check("rsp_beat", {22'd0, bus.rsp_data, bus.rsp_last, bus.rsp_err},
                          {22'd0, e_rsp, m_flag});
                    rsp_log.push_back({bus.rsp_data, bus.rsp_last, bus.rsp_err});
                    last_hs_cyc = cyc;
                    if (rsp_exp_q.size() == 0) end_cmd = 1;
                end
            end
            if (m_busy && bus.mem_error) m_flag = 1;
            if (end_cmd) m_busy = 0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (m_busy) check("accept_while_busy", 1, 0);
                model_accept();
            end
        end

        p_resetn = resetn;
        p_valid  = bus.rsp_valid;
        p_ready  = bus.rsp_ready;
        p_data   = bus.rsp_data;
        p_last   = bus.rsp_last;
    end

    // ---------------- response / error drivers ----------------
    int ready_pct = 100;
    bit stall_mode = 0;
    int stall_cnt = 0;
    int err_pct = 0;
    bit err_force = 0;

    initial begin
        bus.rsp_ready = 1'b0;
        bus.mem_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                if (!bus.rsp_valid) begin
                    stall_cnt = 0;
                    bus.rsp_ready = 1'b0;
                end else if (stall_cnt >= 5) begin
                    bus.rsp_ready = 1'b1;
                end else begin
                    stall_cnt++;
                    bus.rsp_ready = 1'b0;
                end
            end else begin
                bus.rsp_ready = ($urandom_range(0, 99) < ready_pct);
            end
            bus.mem_error = err_force || ($urandom_range(0, 99) < err_pct);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] addr,
                            input logic [2:0] len, input logic [7:0] data);
        int i;
        for (i = 0; i < 300 && !bus.cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        if (!bus.cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy && !m_busy) done = 1;
        end
        if (!done) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic wait_rsp_count(input int n);
        for (int i = 0; i < 500 && rsp_log.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        if (rsp_log.size() < n) check("rsp_count_timeout", rsp_log.size(), n);
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc_log.delete();
        rd_cyc_log.delete();
        rise_cyc_log.delete();
        rsp_log.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int fill_addr [4];
    int rd_before;
    int rsp_before;

    initial begin
        fill_addr[0] = 6; fill_addr[1] = 7; fill_addr[2] = 0; fill_addr[3] = 1;
        for (int i = 0; i < DEPTH; i++) begin
            init_val[i]  = 8'($urandom_range(0, 255));
            model_mem[i] = init_val[i];
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        load_mem = 1'b1;
        @(posedge clk);
        #1;
        load_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        check("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("reset_outputs", {20'd0, busy, bus.mem_wr, bus.mem_rd, bus.rsp_valid,
              bus.rsp_last, bus.rsp_err, bus.mem_addr, 3'd0}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("cmd_ready_after_release", {31'd0, bus.cmd_ready}, 32'd1);

        // single write, nonzero len field must be ignored
        clear_logs();
        send_cmd(2'b00, 3'd3, 3'd5, 8'hA5);
        wait_idle(100);
        check("sw_beats", wr_log.size(), 1);
        if (wr_log.size() == 1) check("sw_beat0", {21'd0, wr_log[0]}, {21'd0, 3'd3, 8'hA5});
        check("sw_acks", rsp_log.size(), 1);
        if (rsp_log.size() == 1) check("sw_ack", {22'd0, rsp_log[0]}, {22'd0, 8'h00, 1'b1, 1'b0});

        // single read returns what was written
        clear_logs();
        send_cmd(2'b01, 3'd3, 3'd2, 8'h00);
        wait_idle(100);
        check("sr_beats", rsp_log.size(), 1);
        if (rsp_log.size() == 1) check("sr_data", {22'd0, rsp_log[0]}, {22'd0, 8'hA5, 1'b1, 1'b0});
        if (rd_cyc_log.size() == 1) check("sr_rd_latency", rd_cyc_log[0] - acc_cyc, 1);
        if (rise_cyc_log.size() == 1) check("sr_rsp_latency", rise_cyc_log[0] - acc_cyc, 3);

        // wrapping fill then burst read of the same window
        clear_logs();
        send_cmd(2'b11, 3'd6, 3'd3, 8'h3C);
        wait_idle(100);
        check("fill_beats", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check("fill_beat", {21'd0, wr_log[i]}, {21'd0, 3'(fill_addr[i]), 8'h3C});
        if (wr_cyc_log.size() == 4) check("fill_consecutive", wr_cyc_log[3] - wr_cyc_log[0], 3);
        clear_logs();
        send_cmd(2'b10, 3'd6, 3'd3, 8'h00);
        wait_idle(200);
        check("br_beats", rsp_log.size(), 4);
        for (int i = 0; i < 4 && i < rsp_log.size(); i++)
            check("br_beat", {22'd0, rsp_log[i]}, {22'd0, 8'h3C, (i == 3) ? 1'b1 : 1'b0, 1'b0});

        // full-depth burst with 5 stall cycles per beat; commands offered while busy
        clear_logs();
        stall_mode = 1;
        send_cmd(2'b10, 3'd0, 3'd7, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 3'd5;
        bus.cmd_data  = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_idle(500);
        stall_mode = 0;
        check("stall_beats", rsp_log.size(), 8);
        if (rsp_log.size() == 8) begin
            check("stall_beat3", {22'd0, rsp_log[3]}, {22'd0, 8'hA5, 1'b0, 1'b0});
            check("stall_beat6", {22'd0, rsp_log[6]}, {22'd0, 8'h3C, 1'b0, 1'b0});
            check("stall_beat7_last", {31'd0, rsp_log[7][1]}, 32'd1);
        end

        // one-cycle target error mid-burst
        clear_logs();
        ready_pct = 100;
        send_cmd(2'b10, 3'd2, 3'd5, 8'h00);
        wait_rsp_count(2);
        @(posedge clk);
        #2 err_force = 1'b1;
        @(posedge clk);
        #2 err_force = 1'b0;
        wait_idle(200);
        check("err_beats", rsp_log.size(), 6);
        if (rsp_log.size() == 6) begin
            check("err_first_clean", {31'd0, rsp_log[0][0]}, 32'd0);
            check("err_last_flag", {31'd0, rsp_log[5][0]}, 32'd1);
        end
        clear_logs();
        send_cmd(2'b01, 3'd3, 3'd0, 8'h00);
        wait_idle(100);
        if (rsp_log.size() == 1) check("err_cleared", {22'd0, rsp_log[0]}, {22'd0, 8'hA5, 1'b1, 1'b0});
        else check("err_cleared_beats", rsp_log.size(), 1);

        // reset in the middle of a burst
        clear_logs();
        send_cmd(2'b10, 3'd0, 3'd7, 8'h00);
        wait_rsp_count(2);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_outputs", {12'd0, busy, bus.cmd_ready, bus.mem_wr, bus.mem_rd,
              bus.rsp_valid, bus.rsp_last, bus.rsp_err, bus.mem_addr, bus.rsp_data, 1'b0}, 32'd0);
        check("midreset_din", {24'd0, bus.mem_din}, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rd_before = rd_cyc_log.size();
        rsp_before = rsp_log.size();
        @(posedge clk);
        #1;
        check("midreset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_stray_rd", rd_cyc_log.size(), rd_before);
        check("midreset_no_stray_rsp", rsp_log.size(), rsp_before);

        // randomized commands with random back-pressure and target errors
        ready_pct = 60;
        err_pct = 5;
        for (int n = 0; n < 40; n++) begin
            send_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                     3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            wait_idle(400);
        end
        err_pct = 0;
        ready_pct = 100;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
